// File: rtl/kch_pkg.sv
// Shared types and constants for the known-CH receive sequencer.
package kch_pkg;

    localparam int WORD_WIDTH = 16;

    localparam logic [WORD_WIDTH-1:0] HOPS_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        PKT_HB  = 2'd0,
        PKT_CHE = 2'd1
    } pkt_type_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HB_CLR  = 3'd1,
        ST_COLLECT = 3'd2,
        ST_STAGE   = 3'd3,
        ST_ISSUE   = 3'd4,
        ST_SETTLE  = 3'd5,
        ST_DONE    = 3'd6
    } kch_state_e;

    function automatic logic [WORD_WIDTH-1:0] sat_inc(input logic [WORD_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/kch_rx_sequencer_if.sv
// Received-packet handshake bus feeding the known-CH sequencer.
interface kch_rx_sequencer_if;
    import kch_pkg::*;

    logic                  pkt_valid;
    logic                  pkt_ready;
    logic [1:0]            pkt_type;
    logic [WORD_WIDTH-1:0] pkt_src;
    logic [WORD_WIDTH-1:0] pkt_hops;
    logic [WORD_WIDTH-1:0] pkt_qvalue;

    modport master (
        output pkt_valid, pkt_type, pkt_src, pkt_hops, pkt_qvalue,
        input  pkt_ready
    );

    modport slave (
        input  pkt_valid, pkt_type, pkt_src, pkt_hops, pkt_qvalue,
        output pkt_ready
    );

endinterface

// File: rtl/kch_window_timer.sv
// Loadable down-counter that saturates at zero; load wins over decrement.
module kch_window_timer
    import kch_pkg::*;
#(
    parameter int W = WORD_WIDTH
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/kch_rx_sequencer.sv
// Decodes HB/CHE packets into knownCH clear/capture pulses with per-round limit and window.
// Optional build macro: KCH_SELF_FILTER_EN drops CHE packets sent by this node.
module kch_rx_sequencer
    import kch_pkg::*;
#(
    parameter int WINDOW_CYCLES = 64,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [WORD_WIDTH-1:0] myNodeID,
    input  logic [WORD_WIDTH-1:0] HB_CHlimit,
    kch_rx_sequencer_if.slave     pkt,
    output logic                  HB_reset,
    output logic                  en_KCH,
    output logic [WORD_WIDTH-1:0] fCH_ID,
    output logic [WORD_WIDTH-1:0] fCH_Hops,
    output logic [WORD_WIDTH-1:0] fCH_QValue,
    output logic [WORD_WIDTH-1:0] ch_count,
    output logic                  round_done
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    kch_state_e            state_q;
    logic                  hb_reset_q, en_kch_q, round_done_q;
    logic [WORD_WIDTH-1:0] fch_id_q, fch_hops_q, fch_qv_q, ch_count_q, limit_q;
    logic [SW-1:0]         settle_q;

    logic win_zero, accept, is_hb, is_che, self_drop, win_dec;

    assign is_hb  = (pkt.pkt_type == PKT_HB);
    assign is_che = (pkt.pkt_type == PKT_CHE);

`ifdef KCH_SELF_FILTER_EN
    assign self_drop = (pkt.pkt_src == myNodeID);
`else
    // myNodeID only matters when self filtering is built in
    logic unused_node_id;
    assign unused_node_id = ^myNodeID;
    assign self_drop      = 1'b0;
`endif

    assign pkt.pkt_ready = (state_q == ST_IDLE) || (state_q == ST_DONE) ||
                           ((state_q == ST_COLLECT) && !win_zero);
    assign accept        = pkt.pkt_valid && pkt.pkt_ready;

    // Window counts from the HB_reset cycle, so HB_CLR decrements as well.
    assign win_dec = (state_q == ST_HB_CLR) || (state_q == ST_COLLECT) ||
                     (state_q == ST_STAGE)  || (state_q == ST_ISSUE)   ||
                     (state_q == ST_SETTLE);

    kch_window_timer #(.W(WORD_WIDTH)) u_window (
        .clk       (clk),
        .nrst      (nrst),
        .load_i    (accept && is_hb),
        .load_val_i(WORD_WIDTH'(WINDOW_CYCLES)),
        .dec_i     (win_dec),
        .zero_o    (win_zero)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= ST_IDLE;
            hb_reset_q   <= 1'b0;
            en_kch_q     <= 1'b0;
            round_done_q <= 1'b0;
            fch_id_q     <= '0;
            fch_hops_q   <= HOPS_INIT;
            fch_qv_q     <= '0;
            ch_count_q   <= '0;
            limit_q      <= '0;
            settle_q     <= '0;
        end else begin
            hb_reset_q <= 1'b0;
            en_kch_q   <= 1'b0;
            if (accept && is_hb) begin
                // An HB restarts the round from any state that is ready.
                state_q      <= ST_HB_CLR;
                hb_reset_q   <= 1'b1;
                ch_count_q   <= '0;
                round_done_q <= 1'b0;
                limit_q      <= HB_CHlimit;
            end else begin
                case (state_q)
                    ST_HB_CLR: state_q <= ST_COLLECT;
                    ST_COLLECT: begin
                        if (accept) begin
                            if (is_che && !self_drop) begin
                                fch_id_q   <= pkt.pkt_src;
                                fch_hops_q <= pkt.pkt_hops;
                                fch_qv_q   <= pkt.pkt_qvalue;
                                state_q    <= ST_STAGE;
                            end
                        end else if (win_zero) begin
                            state_q      <= ST_DONE;
                            round_done_q <= 1'b1;
                        end
                    end
                    ST_STAGE: begin
                        en_kch_q <= 1'b1;
                        state_q  <= ST_ISSUE;
                    end
                    ST_ISSUE: begin
                        ch_count_q <= sat_inc(ch_count_q);
                        settle_q   <= SW'(SETTLE_CYCLES - 1);
                        state_q    <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (settle_q != '0) begin
                            settle_q <= settle_q - 1'b1;
                        end else if (win_zero || (limit_q != '0 && ch_count_q == limit_q)) begin
                            state_q      <= ST_DONE;
                            round_done_q <= 1'b1;
                        end else begin
                            state_q <= ST_COLLECT;
                        end
                    end
                    default: ; // IDLE/DONE drop non-HB packets
                endcase
            end
        end
    end

    assign HB_reset   = hb_reset_q;
    assign en_KCH     = en_kch_q;
    assign fCH_ID     = fch_id_q;
    assign fCH_Hops   = fch_hops_q;
    assign fCH_QValue = fch_qv_q;
    assign ch_count   = ch_count_q;
    assign round_done = round_done_q;

endmodule

// File: tb/tb_kch_rx_sequencer.sv
// Directed self-checking bench for kch_rx_sequencer (WINDOW_CYCLES=64, SETTLE_CYCLES=4).
module tb_kch_rx_sequencer;
    import kch_pkg::*;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [15:0] myNodeID = 16'd12;
    logic [15:0] HB_CHlimit = 16'd0;
    logic        HB_reset, en_KCH, round_done;
    logic [15:0] fCH_ID, fCH_Hops, fCH_QValue, ch_count;
    int          checks = 0;
    int          errors = 0;
    int          en_cnt = 0;
    int          en_base;

    kch_rx_sequencer_if pkt_if ();

    kch_rx_sequencer #(.WINDOW_CYCLES(64), .SETTLE_CYCLES(4)) dut (
        .clk(clk), .nrst(nrst), .myNodeID(myNodeID), .HB_CHlimit(HB_CHlimit),
        .pkt(pkt_if), .HB_reset(HB_reset), .en_KCH(en_KCH), .fCH_ID(fCH_ID),
        .fCH_Hops(fCH_Hops), .fCH_QValue(fCH_QValue), .ch_count(ch_count),
        .round_done(round_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (en_KCH === 1'b1) en_cnt++;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge of the cycle after acceptance.
    task automatic send(input logic [1:0] t, input logic [15:0] s, input logic [15:0] h,
                        input logic [15:0] q);
        int n = 0;
        pkt_if.pkt_valid = 1'b1; pkt_if.pkt_type = t;
        pkt_if.pkt_src = s; pkt_if.pkt_hops = h; pkt_if.pkt_qvalue = q;
        while (pkt_if.pkt_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (pkt_if.pkt_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL send_timeout src=%0d ready never high", s);
        end
        @(negedge clk);
        pkt_if.pkt_valid = 1'b0;
    endtask

    task automatic test_reset();
        step(3);
        checks++;
        if ({HB_reset, en_KCH, round_done} !== 3'b000 || fCH_ID !== 16'h0 ||
            fCH_Hops !== 16'hFFFF || fCH_QValue !== 16'h0 || ch_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs got hb=%b en=%b rd=%b id=%h hops=%h q=%h cnt=%h want 0 0 0 0000 ffff 0000 0000",
                     HB_reset, en_KCH, round_done, fCH_ID, fCH_Hops, fCH_QValue, ch_count);
        end
        checks++;
        if (pkt_if.pkt_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", pkt_if.pkt_ready); end
        nrst = 1'b1;
        step(1);
    endtask

    task automatic test_hb();
        HB_CHlimit = 16'd3;
        send(2'd0, 16'd1, 16'd0, 16'd0);
        checks++;
        if (HB_reset !== 1'b1) begin errors++; $display("FAIL hb_pulse got %b want 1", HB_reset); end
        checks++;
        if (pkt_if.pkt_ready !== 1'b0) begin errors++; $display("FAIL hb_ready_low got %b want 0", pkt_if.pkt_ready); end
        checks++;
        if (ch_count !== 16'd0) begin errors++; $display("FAIL hb_count got %0d want 0", ch_count); end
        step(1);
        checks++;
        if (HB_reset !== 1'b0 || pkt_if.pkt_ready !== 1'b1) begin
            errors++; $display("FAIL hb_single_pulse got hb=%b rdy=%b want 0 1", HB_reset, pkt_if.pkt_ready);
        end
    endtask

    task automatic test_che();
        send(2'd1, 16'd23, 16'd2, 16'h3000);
        checks++;
        if (fCH_ID !== 16'd23 || fCH_Hops !== 16'd2 || fCH_QValue !== 16'h3000 || en_KCH !== 1'b0) begin
            errors++; $display("FAIL che_stage got id=%0d hops=%0d q=%h en=%b want 23 2 3000 0",
                               fCH_ID, fCH_Hops, fCH_QValue, en_KCH);
        end
        step(1);
        checks++;
        if (en_KCH !== 1'b1 || fCH_ID !== 16'd23 || ch_count !== 16'd0) begin
            errors++; $display("FAIL che_issue got en=%b id=%0d cnt=%0d want 1 23 0", en_KCH, fCH_ID, ch_count);
        end
        step(1);
        checks++;
        if (en_KCH !== 1'b0 || ch_count !== 16'd1) begin
            errors++; $display("FAIL che_count got en=%b cnt=%0d want 0 1", en_KCH, ch_count);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pkt_if.pkt_ready !== 1'b0) begin errors++; $display("FAIL che_settle_ready%0d got %b want 0", i, pkt_if.pkt_ready); end
            step(1);
        end
        checks++;
        if (pkt_if.pkt_ready !== 1'b1) begin errors++; $display("FAIL che_post_settle got %b want 1", pkt_if.pkt_ready); end
        en_base = en_cnt;
        send(2'd2, 16'd77, 16'd9, 16'h1111);
        step(3);
        checks++;
        if (fCH_ID !== 16'd23 || en_cnt != en_base || ch_count !== 16'd1 || pkt_if.pkt_ready !== 1'b1) begin
            errors++; $display("FAIL reserved_drop got id=%0d pulses=%0d cnt=%0d rdy=%b want 23 0 1 1",
                               fCH_ID, en_cnt - en_base, ch_count, pkt_if.pkt_ready);
        end
    endtask

    task automatic test_limit();
        HB_CHlimit = 16'd2;
        send(2'd0, 16'd1, 16'd0, 16'd0);
        en_base = en_cnt;
        send(2'd1, 16'd45, 16'd3, 16'h2000);
        send(2'd1, 16'd6, 16'd1, 16'h3800);
        step(5);
        checks++;
        if (round_done !== 1'b0 || ch_count !== 16'd2) begin
            errors++; $display("FAIL limit_pre_done got rd=%b cnt=%0d want 0 2", round_done, ch_count);
        end
        step(1);
        checks++;
        if (round_done !== 1'b1 || pkt_if.pkt_ready !== 1'b1 || en_cnt - en_base != 2 || fCH_ID !== 16'd6) begin
            errors++; $display("FAIL limit_done got rd=%b rdy=%b pulses=%0d id=%0d want 1 1 2 6",
                               round_done, pkt_if.pkt_ready, en_cnt - en_base, fCH_ID);
        end
        send(2'd1, 16'd12, 16'd4, 16'h1000);
        step(3);
        checks++;
        if (en_cnt - en_base != 2 || fCH_ID !== 16'd6 || ch_count !== 16'd2 || round_done !== 1'b1) begin
            errors++; $display("FAIL limit_drop got pulses=%0d id=%0d cnt=%0d rd=%b want 2 6 2 1",
                               en_cnt - en_base, fCH_ID, ch_count, round_done);
        end
    endtask

    task automatic test_window();
        HB_CHlimit = 16'd0;
        send(2'd0, 16'd1, 16'd0, 16'd0);
        en_base = en_cnt;
        checks++;
        if (HB_reset !== 1'b1 || round_done !== 1'b0) begin
            errors++; $display("FAIL win_start got hb=%b rd=%b want 1 0", HB_reset, round_done);
        end
        step(63);
        checks++;
        if (pkt_if.pkt_ready !== 1'b1 || round_done !== 1'b0) begin
            errors++; $display("FAIL win_last_open got rdy=%b rd=%b want 1 0", pkt_if.pkt_ready, round_done);
        end
        step(1);
        pkt_if.pkt_valid = 1'b1; pkt_if.pkt_type = 2'd1;
        pkt_if.pkt_src = 16'd99; pkt_if.pkt_hops = 16'd1; pkt_if.pkt_qvalue = 16'h4000;
        checks++;
        if (pkt_if.pkt_ready !== 1'b0 || round_done !== 1'b0) begin
            errors++; $display("FAIL win_zero got rdy=%b rd=%b want 0 0", pkt_if.pkt_ready, round_done);
        end
        step(1);
        pkt_if.pkt_valid = 1'b0;
        checks++;
        if (round_done !== 1'b1) begin errors++; $display("FAIL win_done got rd=%b want 1", round_done); end
        step(4);
        checks++;
        if (en_cnt != en_base || fCH_ID !== 16'd6 || ch_count !== 16'd0) begin
            errors++; $display("FAIL win_no_capture got pulses=%0d id=%0d cnt=%0d want 0 6 0",
                               en_cnt - en_base, fCH_ID, ch_count);
        end
    endtask

    task automatic test_self();
        send(2'd0, 16'd1, 16'd0, 16'd0);
        en_base = en_cnt;
        send(2'd1, 16'd12, 16'd5, 16'h4000);
        step(7);
`ifdef KCH_SELF_FILTER_EN
        checks++;
        if (en_cnt != en_base || ch_count !== 16'd0 || fCH_ID !== 16'd6 || pkt_if.pkt_ready !== 1'b1) begin
            errors++; $display("FAIL self_filtered got pulses=%0d cnt=%0d id=%0d rdy=%b want 0 0 6 1",
                               en_cnt - en_base, ch_count, fCH_ID, pkt_if.pkt_ready);
        end
`else
        checks++;
        if (en_cnt - en_base != 1 || ch_count !== 16'd1 || fCH_ID !== 16'd12 || fCH_Hops !== 16'd5) begin
            errors++; $display("FAIL self_issued got pulses=%0d cnt=%0d id=%0d hops=%0d want 1 1 12 5",
                               en_cnt - en_base, ch_count, fCH_ID, fCH_Hops);
        end
`endif
    endtask

    task automatic test_reset_mid();
        send(2'd0, 16'd1, 16'd0, 16'd0);
        send(2'd1, 16'd7, 16'd2, 16'h2222);
        step(3);
        checks++;
        if (pkt_if.pkt_ready !== 1'b0 || ch_count !== 16'd1) begin
            errors++; $display("FAIL mid_in_settle got rdy=%b cnt=%0d want 0 1", pkt_if.pkt_ready, ch_count);
        end
        nrst = 1'b0;
        step(1);
        en_base = en_cnt;
        checks++;
        if ({HB_reset, en_KCH, round_done} !== 3'b000 || fCH_ID !== 16'h0 || fCH_Hops !== 16'hFFFF ||
            fCH_QValue !== 16'h0 || ch_count !== 16'h0 || pkt_if.pkt_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset got hb=%b en=%b rd=%b id=%h hops=%h q=%h cnt=%h rdy=%b want 0 0 0 0000 ffff 0000 0000 1",
                               HB_reset, en_KCH, round_done, fCH_ID, fCH_Hops, fCH_QValue, ch_count, pkt_if.pkt_ready);
        end
        step(1);
        nrst = 1'b1;
        step(3);
        checks++;
        if (en_cnt != en_base) begin errors++; $display("FAIL mid_no_pulse got %0d want 0", en_cnt - en_base); end
        send(2'd0, 16'd1, 16'd0, 16'd0);
        checks++;
        if (HB_reset !== 1'b1) begin errors++; $display("FAIL mid_hb got %b want 1", HB_reset); end
        send(2'd1, 16'd33, 16'd1, 16'h1000);
        checks++;
        if (fCH_ID !== 16'd33 || fCH_Hops !== 16'd1 || fCH_QValue !== 16'h1000) begin
            errors++; $display("FAIL mid_stage got id=%0d hops=%0d q=%h want 33 1 1000", fCH_ID, fCH_Hops, fCH_QValue);
        end
        step(1);
        checks++;
        if (en_KCH !== 1'b1) begin errors++; $display("FAIL mid_issue got %b want 1", en_KCH); end
        step(1);
        checks++;
        if (ch_count !== 16'd1) begin errors++; $display("FAIL mid_count got %0d want 1", ch_count); end
    endtask

    initial begin
        pkt_if.pkt_valid = 1'b0; pkt_if.pkt_type = 2'd0;
        pkt_if.pkt_src = '0; pkt_if.pkt_hops = '0; pkt_if.pkt_qvalue = '0;
        @(negedge clk);
        test_reset();
        test_hb();
        test_che();
        test_limit();
        test_window();
        test_self();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
